// File: rtl/multdiv_pkg.sv
// Shared constants for the multdiv sequencer.
// State encoding, default iteration counts and counter width.
package multdiv_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int MULT_STEPS_DEF = 16;
  localparam int DIV_STEPS_DEF  = 32;

  localparam int CNT_W = 6;

endpackage

// File: rtl/step_counter6.sv
// 6-bit up counter with synchronous clear and enable.
// Reset and clear both return the count to zero.
module step_counter6
  import multdiv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (en)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/multdiv_sequencer.sv
// Iterative multiply/divide cycle controller (IDLE/INIT/RUN/DONE).
// Define MULTDIV_PREEMPT_EN to let a new start restart an in-flight op.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int MULT_STEPS = MULT_STEPS_DEF,
  parameter int DIV_STEPS  = DIV_STEPS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic             op_is_div,
  output logic             load,
  output logic             step_en,
  output logic [CNT_W-1:0] step_idx,
  output logic             busy,
  output logic             result_rdy
);

  if (MULT_STEPS < 1 || MULT_STEPS > 64) begin : g_bad_mult
    $error("MULT_STEPS must be in 1..64");
  end
  if (DIV_STEPS < 1 || DIV_STEPS > 64) begin : g_bad_div
    $error("DIV_STEPS must be in 1..64");
  end

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_STEPS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_STEPS - 1);

  logic [1:0]       state_q, state_d;
  logic             op_div_q, op_div_d;
  logic             cnt_clr, cnt_en;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;
  logic             start;
  logic             can_start;

  assign start = ctrl_MULT | ctrl_DIV;
  assign last  = op_div_q ? DIV_LAST : MULT_LAST;

`ifdef MULTDIV_PREEMPT_EN
  assign can_start = 1'b1;
`else
  assign can_start = (state_q == ST_IDLE) |
                     (state_q == ST_DONE);
`endif

  always_comb begin
    state_d  = state_q;
    op_div_d = op_div_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_INIT: state_d = ST_RUN;
      ST_RUN: begin
        if (cnt == last)
          state_d = ST_DONE;
        else
          cnt_en = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
    endcase
    // Multiply wins when both starts arrive together.
    if (start && can_start) begin
      state_d  = ST_INIT;
      op_div_d = ctrl_DIV & ~ctrl_MULT;
      cnt_clr  = 1'b1;
      cnt_en   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_div_q <= op_div_d;
    end
  end

  step_counter6 u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt)
  );

  assign op_is_div  = op_div_q;
  assign load       = (state_q == ST_INIT);
  assign step_en    = (state_q == ST_RUN);
  assign busy       = load | step_en;
  assign result_rdy = (state_q == ST_DONE);
  assign step_idx   = step_en ? cnt : '0;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer with default step counts.
// Outputs are checked 1ns after each rising edge.
module tb_multdiv_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ctrl_MULT = 1'b0;
  logic       ctrl_DIV = 1'b0;
  logic       op_is_div;
  logic       load;
  logic       step_en;
  logic [5:0] step_idx;
  logic       busy;
  logic       result_rdy;

  int vectors = 0;
  int fails = 0;

  multdiv_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .ctrl_MULT  (ctrl_MULT),
    .ctrl_DIV   (ctrl_DIV),
    .op_is_div  (op_is_div),
    .load       (load),
    .step_en    (step_en),
    .step_idx   (step_idx),
    .busy       (busy),
    .result_rdy (result_rdy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] ev(
    input logic op, input logic ld, input logic se,
    input logic by, input logic rr, input int idx
  );
    return {op, ld, se, by, rr, 6'(idx)};
  endfunction

  task automatic chk(input string tag, input logic [10:0] exp);
    logic [10:0] obs;
    obs = {op_is_div, load, step_en, busy, result_rdy, step_idx};
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b (op,ld,se,busy,rdy,idx)",
             tag, obs, exp);
    end
  endtask

  initial begin
    // reset then idle
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("idle%0d", i), ev(0, 0, 0, 0, 0, 0));
    end

    // multiply, defaults
    ctrl_MULT = 1'b1;
    tick();
    ctrl_MULT = 1'b0;
    chk("mul_init", ev(0, 1, 0, 1, 0, 0));
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("mul_run%0d", i), ev(0, 0, 1, 1, 0, i));
    end
    tick();
    chk("mul_done", ev(0, 0, 0, 0, 1, 0));
    tick();
    chk("mul_idle", ev(0, 0, 0, 0, 0, 0));

    // divide
    ctrl_DIV = 1'b1;
    tick();
    ctrl_DIV = 1'b0;
    chk("div_init", ev(1, 1, 0, 1, 0, 0));
    for (int i = 0; i < 32; i++) begin
      tick();
      chk($sformatf("div_run%0d", i), ev(1, 0, 1, 1, 0, i));
    end
    tick();
    chk("div_done", ev(1, 0, 0, 0, 1, 0));

    // both starts: multiply wins, then back-to-back divide
    ctrl_MULT = 1'b1;
    ctrl_DIV = 1'b1;
    tick();
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    chk("both_init", ev(0, 1, 0, 1, 0, 0));
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("both_run%0d", i), ev(0, 0, 1, 1, 0, i));
    end
    tick();
    chk("both_done18", ev(0, 0, 0, 0, 1, 0));
    ctrl_DIV = 1'b1;
    tick();
    ctrl_DIV = 1'b0;
    chk("b2b_init19", ev(1, 1, 0, 1, 0, 0));
    for (int i = 0; i < 32; i++) begin
      tick();
      chk($sformatf("b2b_run%0d", i), ev(1, 0, 1, 1, 0, i));
    end
    tick();
    chk("b2b_done52", ev(1, 0, 0, 0, 1, 0));

    // multiply at edge 0, divide request at edge 5
    ctrl_MULT = 1'b1;
    tick();
    ctrl_MULT = 1'b0;
    chk("pre_init", ev(0, 1, 0, 1, 0, 0));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("pre_run%0d", i), ev(0, 0, 1, 1, 0, i));
    end
    ctrl_DIV = 1'b1;
    tick();
    ctrl_DIV = 1'b0;
`ifdef MULTDIV_PREEMPT_EN
    chk("pre_reinit6", ev(1, 1, 0, 1, 0, 0));
    for (int i = 0; i < 32; i++) begin
      tick();
      chk($sformatf("pre_drun%0d", i), ev(1, 0, 1, 1, 0, i));
    end
    tick();
    chk("pre_ddone39", ev(1, 0, 0, 0, 1, 0));
`else
    chk("ign_run4", ev(0, 0, 1, 1, 0, 4));
    for (int i = 5; i < 16; i++) begin
      tick();
      chk($sformatf("ign_run%0d", i), ev(0, 0, 1, 1, 0, i));
    end
    tick();
    chk("ign_done18", ev(0, 0, 0, 0, 1, 0));
    tick();
    chk("ign_idle", ev(0, 0, 0, 0, 0, 0));
`endif

    // reset mid-multiply at edge 10, start with reset dropped
    ctrl_MULT = 1'b1;
    tick();
    ctrl_MULT = 1'b0;
    chk("rst_init", ev(0, 1, 0, 1, 0, 0));
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("rst_run%0d", i), ev(0, 0, 1, 1, 0, i));
    end
    reset = 1'b1;
    ctrl_MULT = 1'b1;
    tick();
    reset = 1'b0;
    ctrl_MULT = 1'b0;
    chk("rst_c11", ev(0, 0, 0, 0, 0, 0));
    tick();
    chk("rst_c12", ev(0, 0, 0, 0, 0, 0));
    ctrl_MULT = 1'b1;
    tick();
    ctrl_MULT = 1'b0;
    chk("rst_init13", ev(0, 1, 0, 1, 0, 0));
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("rst_mrun%0d", i), ev(0, 0, 1, 1, 0, i));
    end
    tick();
    chk("rst_done30", ev(0, 0, 0, 0, 1, 0));
    tick();
    chk("rst_idle31", ev(0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
